// File: rtl/bs_gnrtr_n_rbtr.sv
// Bus generator and round-robin arbiter for a multi-device packet bus.
// Each bus pops one pending device, decodes the destination and pushes it.
module bs_gnrtr_n_rbtr #(
    parameter int          bits      = 1,
    parameter int          drvrs     = 4,
    parameter int          pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [bits-1:0][drvrs-1:0]              pndng,
    output logic [bits-1:0][drvrs-1:0]              push,
    output logic [bits-1:0][drvrs-1:0]              pop,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

    localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } st_t;

    for (genvar b = 0; b < bits; b++) begin : g_bus

        st_t                st_q, st_d;
        logic [PW-1:0]      ptr_q, ptr_d;
        logic [PW-1:0]      sel_q, sel_d;
        logic [pckg_sz-1:0] pkt_q, pkt_d;
        logic [drvrs-1:0]   pop_q, pop_d;
        logic [drvrs-1:0]   push_q, push_d;
        logic [7:0]         dest;
        logic               found;
        logic [PW-1:0]      cand;
        logic [PW-1:0]      idx;
        int                 j;

        // Next-state, grant search and registered-output precomputation.
        always_comb begin
            st_d   = st_q;
            ptr_d  = ptr_q;
            sel_d  = sel_q;
            pkt_d  = pkt_q;
            pop_d  = '0;
            push_d = '0;
            dest   = '0;
            found  = 1'b0;
            cand   = '0;
            idx    = '0;
            j      = 0;
            unique case (st_q)
                IDLE: begin
                    for (int i = 0; i < drvrs; i++) begin
                        j = int'(ptr_q) + i;
                        if (j >= drvrs) j = j - drvrs;
                        idx = PW'(j);
                        if (!found && pndng[b][idx]) begin
                            found = 1'b1;
                            cand  = idx;
                        end
                    end
                    if (found) begin
                        sel_d       = cand;
                        pop_d[cand] = 1'b1;
                        st_d        = POP;
                    end
                end
                POP: begin
                    // Pushes are decoded from the popped head now so
                    // they leave a register in the following cycle.
                    pkt_d = D_pop[b][sel_q];
                    dest  = D_pop[b][sel_q][pckg_sz-1 -: 8];
                    if (int'(sel_q) == drvrs - 1) ptr_d = '0;
                    else ptr_d = sel_q + 1'b1;
                    if (dest == broadcast) begin
                        push_d        = '1;
                        push_d[sel_q] = 1'b0;
                    end else if (int'(dest) < drvrs) begin
                        push_d[dest[PW-1:0]] = 1'b1;
                    end
                    st_d = PUSH;
                end
                PUSH: begin
                    st_d = IDLE;
                end
                default: begin
                    st_d = IDLE;
                end
            endcase
        end

        // State, pointer, packet and strobe registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                st_q   <= IDLE;
                ptr_q  <= '0;
                sel_q  <= '0;
                pkt_q  <= '0;
                pop_q  <= '0;
                push_q <= '0;
            end else begin
                st_q   <= st_d;
                ptr_q  <= ptr_d;
                sel_q  <= sel_d;
                pkt_q  <= pkt_d;
                pop_q  <= pop_d;
                push_q <= push_d;
            end
        end

        assign pop[b]  = pop_q;
        assign push[b] = push_q;

        for (genvar d = 0; d < drvrs; d++) begin : g_dev
            assign D_push[b][d] = pkt_q;
        end
    end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Scoreboard bench for bs_gnrtr_n_rbtr: device FIFO models feed the
// arbiter, expected pop/push events are queued and checked by a monitor.
module tb_bs_gnrtr_n_rbtr;

    localparam int B = 1;
    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [B-1:0][N-1:0]        pndng;
    logic [B-1:0][N-1:0]        push;
    logic [B-1:0][N-1:0]        pop;
    logic [B-1:0][N-1:0][W-1:0] D_pop;
    logic [B-1:0][N-1:0][W-1:0] D_push;

    typedef struct {
        logic         is_push;
        logic [N-1:0] mask;
        logic [W-1:0] data;
    } ev_t;

    ev_t          sb[$];
    logic [W-1:0] fq[N][$];
    logic [N-1:0] rm = '0;
    int           pop_cyc[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    bs_gnrtr_n_rbtr #(
        .bits(B), .drvrs(N), .pckg_sz(W), .broadcast(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .push(push),
        .pop(pop), .D_pop(D_pop), .D_push(D_push)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic void refresh();
        for (int d = 0; d < N; d++) begin
            pndng[0][d] = (fq[d].size() != 0);
            D_pop[0][d] = (fq[d].size() != 0) ? fq[d][0] : '0;
        end
    endfunction

    initial refresh();

    // Device transmit FIFO: head leaves after the pop cycle has been sampled.
    always @(negedge clk) begin
        for (int d = 0; d < N; d++)
            if (rm[d] && fq[d].size() != 0) void'(fq[d].pop_front());
        rm = pop[0];
        refresh();
    end

    task automatic chk_ev(input logic kind, input logic [N-1:0] m);
        ev_t e;
        logic ok;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got mask %b data %h, none required",
                     kind ? "push" : "pop", m, D_push[0][0]);
        end else begin
            e  = sb.pop_front();
            ok = (e.is_push == kind) && (e.mask == m);
            if (kind)
                for (int d = 0; d < N; d++)
                    if (D_push[0][d] !== e.data) ok = 1'b0;
            if (!ok) begin
                errors++;
                $display("FAIL %s_event: got mask %b data %h, required %s mask %b data %h",
                         kind ? "push" : "pop", m, D_push[0][0],
                         e.is_push ? "push" : "pop", e.mask, e.data);
            end
        end
    endtask

    // Monitor: any strobe activity is matched against the scoreboard.
    always @(negedge clk) begin
        if (pop[0] != '0) begin
            pop_cyc.push_back(cyc);
            chk_ev(1'b0, pop[0]);
        end
        if (push[0] != '0) chk_ev(1'b1, push[0]);
    end

    task automatic exp_pop(input int d);
        ev_t e;
        e.is_push = 1'b0;
        e.mask    = N'(1) << d;
        e.data    = '0;
        sb.push_back(e);
    endtask

    task automatic exp_push(input logic [N-1:0] m, input logic [W-1:0] v);
        ev_t e;
        e.is_push = 1'b1;
        e.mask    = m;
        e.data    = v;
        sb.push_back(e);
    endtask

    task automatic load(input int d, input logic [W-1:0] v);
        fq[d].push_back(v);
        refresh();
    endtask

    function automatic bit busy();
        busy = (sb.size() != 0);
        for (int d = 0; d < N; d++)
            if (fq[d].size() != 0) busy = 1'b1;
    endfunction

    task automatic drain(input string name, input int max);
        int n = 0;
        while (busy() && n < max) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d events still expected, required 0",
                     name, sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_idle(input string name);
        checks++;
        if (push !== '0 || pop !== '0 || D_push !== '0) begin
            errors++;
            $display("FAIL %s: push %b pop %b D_push %h, required all 0",
                     name, push, pop, D_push);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not end, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with all devices pending, then a full round-robin sweep.
        load(0, 16'h01A0);
        load(0, 16'h01A4);
        load(1, 16'h0211);
        load(2, 16'h0322);
        load(3, 16'h0033);
        repeat (2) begin
            @(negedge clk);
            chk_idle("reset_outputs");
        end
        exp_pop(0); exp_push(4'b0010, 16'h01A0);
        exp_pop(1); exp_push(4'b0100, 16'h0211);
        exp_pop(2); exp_push(4'b1000, 16'h0322);
        exp_pop(3); exp_push(4'b0001, 16'h0033);
        exp_pop(0); exp_push(4'b0010, 16'h01A4);
        pop_cyc.delete();
        reset = 1'b0;
        drain("round_robin", 60);
        checks++;
        if (pop_cyc.size() != 5) begin
            errors++;
            $display("FAIL rr_pop_count: got %0d, required 5", pop_cyc.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (pop_cyc[i] - pop_cyc[i-1] != 3) begin
                    errors++;
                    $display("FAIL rr_pop_gap: got %0d, required 3",
                             pop_cyc[i] - pop_cyc[i-1]);
                end
            end
        end

        // Unicast to dev2.
        exp_pop(0); exp_push(4'b0100, 16'h02AB);
        load(0, 16'h02AB);
        drain("unicast", 30);

        // Broadcast from dev1 excludes the source.
        exp_pop(1); exp_push(4'b1101, 16'hFF12);
        load(1, 16'hFF12);
        drain("broadcast", 30);

        // Invalid ID dropped; ptr=3 next, self-addressed still delivered.
        exp_pop(2);
        exp_pop(3); exp_push(4'b1000, 16'h0311);
        exp_pop(0); exp_push(4'b0100, 16'h0266);
        load(0, 16'h0266);
        load(2, 16'h07CD);
        load(3, 16'h0311);
        drain("invalid_id", 40);

        // Reset during pop of dev3 aborts the packet.
        exp_pop(3);
        load(3, 16'h0155);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!pop[0][3] && n < 20);
            checks++;
            if (!pop[0][3]) begin
                errors++;
                $display("FAIL wait_pop3: pop %b, required 1000", pop[0]);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        chk_idle("abort_reset");
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_idle("abort_no_push");
        end
        // ptr returned to 0: dev0 must win over dev3.
        exp_pop(0); exp_push(4'b0010, 16'h0100);
        exp_pop(3); exp_push(4'b0100, 16'h0200);
        load(0, 16'h0100);
        load(3, 16'h0200);
        drain("after_abort", 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
